vic_video_timing: RTL and testbench

Parametrised successor to the VIC timing/address block: generates horizontal and vertical counters, sync, blank and composite signals from an external pixel strobe. It also provides a per-line/per-frame start pulse, a latched character-code register and the 6-bit video RAM address multiplexer. It sits between the board clock/strobe inputs and the video RAM, feeding the video output stage and game-specific renderers.

---
 rtl/vic_video_timing.sv | 167 ++++++++++++++++
 tb/tb_vic_video_timing.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vic_video_timing.sv
// vic_video_timing: pixel-strobe driven horizontal/vertical timing generator
// with sync/blank/composite outputs, line/frame start pulses, a latched
// character code and the 6-bit video RAM address multiplexer.
// Optional feature macro: VIC_TIMING_FLIP_EN (cocktail flip of the mux
// counter bits while flip=1; hcnt/vcnt outputs always stay raw).
module vic_video_timing #(
  parameter int CW       = 9,
  parameter int HTOTAL   = 327,
  parameter int HBSTART  = 255,
  parameter int HBEND    = 327,
  parameter int HSSTART  = 272,
  parameter int HSEND    = 304,
  parameter int VTOTAL   = 262,
  parameter int VBSTART  = 224,
  parameter int VBEND    = 0,
  parameter int VSSTART  = 236,
  parameter int VSEND    = 240,
  parameter int HSTART   = 1,
  parameter int SRC_RISE = 0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          src,
  input  logic          msb,
  input  logic          m1,
  input  logic          m2,
  input  logic          m4,
  input  logic          flip,
  input  logic [11:0]   addr,
  input  logic [7:0]    data,
  output logic [CW-1:0] hcnt,
  output logic [CW-1:0] vcnt,
  output logic          hsync,
  output logic          vsync,
  output logic          hblank,
  output logic          vblank,
  output logic          csync,
  output logic          cblank_n,
  output logic          line_start,
  output logic          frame_start,
  output logic [5:0]    ram_addr
);

  localparam logic [CW-1:0] H_TOTAL   = CW'(HTOTAL);
  localparam logic [CW-1:0] H_BSTART  = CW'(HBSTART);
  localparam logic [CW-1:0] H_BEND    = CW'(HBEND);
  localparam logic [CW-1:0] H_SSTART  = CW'(HSSTART);
  localparam logic [CW-1:0] H_SEND    = CW'(HSEND);
  localparam logic [CW-1:0] V_TOTAL   = CW'(VTOTAL);
  localparam logic [CW-1:0] V_BSTART  = CW'(VBSTART);
  localparam logic [CW-1:0] V_BEND    = CW'(VBEND);
  localparam logic [CW-1:0] V_SSTART  = CW'(VSSTART);
  localparam logic [CW-1:0] V_SEND    = CW'(VSEND);
  localparam logic [CW-1:0] H_RESET   = CW'(HSTART);

  logic       src_last;
  logic       msb_last;
  logic       armed;
  logic       src_edge;
  logic       strobe;
  logic [4:0] c;
  logic [4:0] h_sel;
  logic [7:0] v_sel;

  // Pixel strobe: selected edge of src against its last sampled level, gated
  // until the first clock after reset so a level held across reset never counts.
  always_comb begin
    if (SRC_RISE != 0) src_edge = src & ~src_last;
    else               src_edge = ~src & src_last;
    strobe = armed & src_edge;
  end

  // Counters, sync/blank flags and start pulses; all decisions use pre-increment counts.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      src_last    <= 1'b0;
      armed       <= 1'b0;
      hcnt        <= H_RESET;
      vcnt        <= '0;
      hsync       <= 1'b0;
      vsync       <= 1'b0;
      hblank      <= 1'b0;
      vblank      <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here so every comparison below sees the
      // counter value from before this edge, not the one being written.
      src_last    <= src;
      armed       <= 1'b1;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      if (strobe) begin
        if (hcnt == H_TOTAL) begin
          hcnt       <= '0;
          line_start <= 1'b1;
        end else begin
          hcnt <= hcnt + 1'b1;
        end
        // Clear is tested first so it wins when start and end coincide.
        if (hcnt == H_BEND)        hblank <= 1'b0;
        else if (hcnt == H_BSTART) hblank <= 1'b1;
        if (hcnt == H_SEND)        hsync  <= 1'b0;
        else if (hcnt == H_SSTART) hsync  <= 1'b1;
        if (hcnt == H_SSTART) begin
          if (vcnt == V_TOTAL) begin
            vcnt        <= '0;
            frame_start <= 1'b1;
          end else begin
            vcnt <= vcnt + 1'b1;
          end
          if (vcnt == V_BEND)        vblank <= 1'b0;
          else if (vcnt == V_BSTART) vblank <= 1'b1;
          if (vcnt == V_SEND)        vsync  <= 1'b0;
          else if (vcnt == V_SSTART) vsync  <= 1'b1;
        end
      end
    end
  end

  // Character latch: capture the code bits on a rising msb edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      msb_last <= 1'b0;
      c        <= '0;
    end else begin
      msb_last <= msb;
      if (msb & ~msb_last) c <= data[7:3];
    end
  end

  // Counter bits presented to the address mux, optionally mirrored for cocktail mode.
  always_comb begin
    h_sel = hcnt[7:3];
    v_sel = vcnt[7:0];
`ifdef VIC_TIMING_FLIP_EN
    if (flip) begin
      h_sel = ~hcnt[7:3];
      v_sel = ~vcnt[7:0];
    end
`endif
  end

`ifndef VIC_TIMING_FLIP_EN
  // flip has no effect in this build; tie it off explicitly.
  logic unused_flip;
  assign unused_flip = flip;
`endif

  // Video RAM address multiplexer.
  always_comb begin
    ram_addr = 6'b0;
    case ({m4, m2, m1})
      3'd0:    ram_addr = addr[5:0];
      3'd1:    ram_addr = addr[11:6];
      3'd2:    ram_addr = {v_sel[3], h_sel[4:0]};
      3'd3:    ram_addr = {2'b00, v_sel[7:4]};
      3'd4:    ram_addr = {data[2:0], v_sel[2:0]};
      3'd5:    ram_addr = {1'b1, c[4:0]};
      default: ram_addr = 6'b0;
    endcase
  end

  assign csync    = hsync ^ vsync;
  assign cblank_n = ~(hblank | vblank);

endmodule

// File: tb/tb_vic_video_timing.sv
// Self-checking bench for vic_video_timing: a default-geometry instance and a
// small-geometry instance (blank start == blank end) driven from the same
// inputs, compared every cycle against an arithmetic model of the timing rules.
module tb_vic_video_timing;

  typedef struct {
    int htotal, hbstart, hbend, hsstart, hsend;
    int vtotal, vbstart, vbend, vsstart, vsend, hstart;
  } geom_t;

  typedef struct {
    logic [8:0] hcnt, vcnt;
    logic hsync, vsync, hblank, vblank, line_start, frame_start;
  } timing_t;

  typedef struct {
    logic [2:0]  m;
    logic [11:0] addr;
    logic [7:0]  data;
    logic [5:0]  exp_ram;
  } mux_vec_t;

  logic clk = 1'b0;
  logic reset, src, msb, m1, m2, m4, flip;
  logic [11:0] addr;
  logic [7:0]  data;

  logic [8:0] hcnt_d, vcnt_d, hcnt_s, vcnt_s;
  logic hsync_d, vsync_d, hblank_d, vblank_d, csync_d, cblank_n_d, line_start_d, frame_start_d;
  logic hsync_s, vsync_s, hblank_s, vblank_s, csync_s, cblank_n_s, line_start_s, frame_start_s;
  logic [5:0] ram_addr_d, ram_addr_s;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: strobes counted since reset, plus bench-side edge tracking.
  int   k;
  bit   pulsed;
  bit   armed_m;
  logic src_q, msb_q;
  logic [4:0] c_m;

  geom_t g_def, g_small;
  mux_vec_t vecs[8];

  int prev_ls_d, prev_ls_s, hblank_s_high;

  always #5 clk = ~clk;

  vic_video_timing u_def (
    .clk(clk), .reset(reset), .src(src), .msb(msb), .m1(m1), .m2(m2), .m4(m4),
    .flip(flip), .addr(addr), .data(data),
    .hcnt(hcnt_d), .vcnt(vcnt_d), .hsync(hsync_d), .vsync(vsync_d),
    .hblank(hblank_d), .vblank(vblank_d), .csync(csync_d), .cblank_n(cblank_n_d),
    .line_start(line_start_d), .frame_start(frame_start_d), .ram_addr(ram_addr_d)
  );

  vic_video_timing #(
    .HTOTAL(9), .HBSTART(5), .HBEND(5), .HSSTART(6), .HSEND(8),
    .VTOTAL(6), .VBSTART(4), .VBEND(1), .VSSTART(5), .VSEND(6), .HSTART(1)
  ) u_small (
    .clk(clk), .reset(reset), .src(src), .msb(msb), .m1(m1), .m2(m2), .m4(m4),
    .flip(flip), .addr(addr), .data(data),
    .hcnt(hcnt_s), .vcnt(vcnt_s), .hsync(hsync_s), .vsync(vsync_s),
    .hblank(hblank_s), .vblank(vblank_s), .csync(csync_s), .cblank_n(cblank_n_s),
    .line_start(line_start_s), .frame_start(frame_start_s), .ram_addr(ram_addr_s)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (strobes=%0d, t=%0t)", name, got, exp, k, $time);
    end
  endtask

  // Flag state after a walk over visited positions: the most recent hit decides,
  // an end hit beats a start hit on the same position, no hit means low.
  function automatic bit flag_after(int pre, int visited, int st, int en, int total);
    int p = pre;
    for (int i = 0; i < visited && i <= total; i++) begin
      if (p == en) return 1'b0;
      if (p == st) return 1'b1;
      p = (p == 0) ? total : p - 1;
    end
    return 1'b0;
  endfunction

  // Expected timing outputs after k strobes, computed directly from counts.
  function automatic timing_t model_timing(geom_t g, int ks, bit pl);
    timing_t t;
    int ht1, vt1, pre, j0, nv, vpre;
    ht1 = g.htotal + 1;
    vt1 = g.vtotal + 1;
    t = '{default: '0};
    t.hcnt = 9'(g.hstart);
    if (ks == 0) return t;
    t.hcnt   = 9'((g.hstart + ks) % ht1);
    pre      = (g.hstart + ks - 1) % ht1;
    t.hblank = flag_after(pre, ks, g.hbstart, g.hbend, g.htotal);
    t.hsync  = flag_after(pre, ks, g.hsstart, g.hsend, g.htotal);
    j0 = (g.hsstart - g.hstart + ht1) % ht1;
    nv = (ks > j0) ? (ks - 1 - j0) / ht1 + 1 : 0;
    t.vcnt = 9'(nv % vt1);
    if (nv > 0) begin
      vpre     = (nv - 1) % vt1;
      t.vblank = flag_after(vpre, nv, g.vbstart, g.vbend, g.vtotal);
      t.vsync  = flag_after(vpre, nv, g.vsstart, g.vsend, g.vtotal);
    end
    t.line_start  = pl && (t.hcnt == 0);
    t.frame_start = pl && (pre == g.hsstart) && (nv > 0) && (t.vcnt == 0);
    return t;
  endfunction

  function automatic logic [5:0] ram_model(logic [2:0] m, logic [11:0] a, logic [7:0] d,
                                           logic [4:0] cc, logic [8:0] h, logic [8:0] v, logic f);
    logic [4:0] hh;
    logic [7:0] vv;
    hh = h[7:3];
    vv = v[7:0];
`ifdef VIC_TIMING_FLIP_EN
    if (f) begin
      hh = ~hh;
      vv = ~vv;
    end
`endif
    case (m)
      3'd0:    return a[5:0];
      3'd1:    return a[11:6];
      3'd2:    return {vv[3], hh};
      3'd3:    return {2'b00, vv[7:4]};
      3'd4:    return {d[2:0], vv[2:0]};
      3'd5:    return {1'b1, cc};
      default: return 6'b0;
    endcase
  endfunction

  function automatic logic [31:0] pack_exp(timing_t t);
    logic [5:0] ra;
    ra = ram_model({m4, m2, m1}, addr, data, c_m, t.hcnt, t.vcnt, flip);
    return {t.hcnt, t.vcnt, t.hsync, t.vsync, t.hblank, t.vblank, t.line_start,
            t.frame_start, t.hsync ^ t.vsync, ~(t.hblank | t.vblank), ra};
  endfunction

  task automatic reset_model();
    k = 0; pulsed = 0; armed_m = 0; src_q = 1'b0; msb_q = 1'b0; c_m = '0;
  endtask

  task automatic check_all();
    check("timing_def", {hcnt_d, vcnt_d, hsync_d, vsync_d, hblank_d, vblank_d, line_start_d,
                         frame_start_d, csync_d, cblank_n_d, ram_addr_d},
          pack_exp(model_timing(g_def, k, pulsed)));
    check("timing_small", {hcnt_s, vcnt_s, hsync_s, vsync_s, hblank_s, vblank_s, line_start_s,
                           frame_start_s, csync_s, cblank_n_s, ram_addr_s},
          pack_exp(model_timing(g_small, k, pulsed)));
  endtask

  // One clock: inputs already driven at the negedge; advance model, then check.
  task automatic tick();
    bit pend, msb_rise;
    logic [4:0] d_hi;
    pend     = armed_m && src_q && !src;
    msb_rise = msb && !msb_q;
    d_hi     = data[7:3];
    @(posedge clk);
    if (!reset) begin
      if (pend) k++;
      pulsed  = pend;
      src_q   = src;
      msb_q   = msb;
      if (msb_rise) c_m = d_hi;
      armed_m = 1;
    end
    @(negedge clk);
    check_all();
  endtask

  task automatic strobes(int n);
    repeat (n) begin
      src = 1'b1; tick(); tick();
      src = 1'b0; tick(); tick();
    end
  endtask

  task automatic set_m(logic [2:0] m);
    {m4, m2, m1} = m;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    g_def   = '{327, 255, 327, 272, 304, 262, 224, 0, 236, 240, 1};
    g_small = '{9, 5, 5, 6, 8, 6, 4, 1, 5, 6, 1};
    // Mux vectors in the reset state: H=0, V=0, c=0, flip=0.
    vecs[0] = '{3'd0, 12'hABC, 8'h00, 6'h3C};
    vecs[1] = '{3'd1, 12'hABC, 8'h00, 6'h2A};
    vecs[2] = '{3'd2, 12'hFFF, 8'hFF, 6'h00};
    vecs[3] = '{3'd3, 12'hFFF, 8'hFF, 6'h00};
    vecs[4] = '{3'd4, 12'h000, 8'h05, 6'h28};
    vecs[5] = '{3'd5, 12'hFFF, 8'hFF, 6'h20};
    vecs[6] = '{3'd6, 12'hFFF, 8'hFF, 6'h00};
    vecs[7] = '{3'd7, 12'hFFF, 8'hFF, 6'h00};

    reset = 1'b1; src = 1'b1; msb = 1'b0; flip = 1'b0;
    set_m(3'd0); addr = '0; data = '0;
    reset_model();
    @(negedge clk);
    tick();

    // Reset state, including derived outputs.
    check("rst_hcnt", hcnt_d, 1);
    check("rst_vcnt", vcnt_d, 0);
    check("rst_flags", {hsync_d, vsync_d, hblank_d, vblank_d, line_start_d, frame_start_d}, 0);
    check("rst_csync", csync_d, 0);
    check("rst_cblank_n", cblank_n_d, 1);

    for (int i = 0; i < 8; i++) begin
      set_m(vecs[i].m); addr = vecs[i].addr; data = vecs[i].data;
      #1;
      check($sformatf("mux_vec%0d_def", i), ram_addr_d, vecs[i].exp_ram);
      check($sformatf("mux_vec%0d_small", i), ram_addr_s, vecs[i].exp_ram);
      tick();
    end

    // Release reset with src high: no count until the next falling edge.
    reset = 1'b0;
    repeat (3) tick();
    check("release_no_count", hcnt_d, 1);
    src = 1'b0;
    tick(); tick();
    check("first_fall_count", hcnt_d, 2);

    // Character latch and mux selects 5 and 1.
    data = 8'hA8; msb = 1'b1; tick();
    msb = 1'b0; tick();
    set_m(3'd5); #1;
    check("char_latch_m5", ram_addr_d, 6'h35);
    set_m(3'd1); addr = 12'hFC0; #1;
    check("addr_hi_m1", ram_addr_d, 6'h3F);

    // Advance to hcnt=0F8, vcnt=8 and check select 2 raw and flipped.
    set_m(3'd2); data = 8'h00; addr = 12'h000;
    strobes(2870);
    check("pos_hcnt", hcnt_d, 9'h0F8);
    check("pos_vcnt", vcnt_d, 9'h008);
    check("m2_raw", ram_addr_d, 6'h3F);
    flip = 1'b1; #1;
`ifdef VIC_TIMING_FLIP_EN
    check("m2_flip", ram_addr_d, 6'h00);
`else
    check("m2_flip_ignored", ram_addr_d, 6'h3F);
`endif
    flip = 1'b0;

    // Into the hsync/hblank window, then reset mid-line without a clock edge.
    strobes(32);
    check("mid_hcnt", hcnt_d, 9'd280);
    check("mid_hsync", hsync_d, 1);
    check("mid_hblank", hblank_d, 1);
    #2;
    reset = 1'b1;
    #1;
    check("async_hcnt", hcnt_d, 1);
    check("async_vcnt", vcnt_d, 0);
    check("async_flags", {hsync_d, vsync_d, hblank_d, vblank_d, line_start_d, frame_start_d}, 0);
    check("async_cblank_n", cblank_n_d, 1);
    check("async_small", {hcnt_s, vcnt_s, hsync_s, vsync_s, hblank_s, vblank_s}, {9'd1, 9'd0, 4'b0});
    reset_model();
    @(negedge clk);
    tick();
    reset = 1'b0;

    // Randomized run against the model, with pulse spacing tracking.
    prev_ls_d = -1; prev_ls_s = -1; hblank_s_high = 0;
    for (int n = 0; n < 2200; n++) begin
      int hold;
      src  = ~src;
      hold = $urandom_range(2, 4);
      repeat (hold) begin
        msb  = ($urandom_range(0, 3) == 0);
        set_m(3'($urandom_range(0, 7)));
        flip = 1'($urandom_range(0, 1));
        addr = 12'($urandom);
        data = 8'($urandom);
        tick();
        if (hblank_s) hblank_s_high++;
        if (line_start_s) begin
          if (prev_ls_s >= 0) check("line_spacing_small", k - prev_ls_s, 10);
          prev_ls_s = k;
        end
        if (line_start_d) begin
          if (prev_ls_d >= 0) check("line_spacing_def", k - prev_ls_d, 328);
          prev_ls_d = k;
        end
      end
    end
    check("small_hblank_never", hblank_s_high, 0);
    check("def_lines_seen", (prev_ls_d >= 0), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
